// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the dual-clock FIFO.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_AF_LEVEL    = 12;
  localparam int DEF_AE_LEVEL    = 2;
  localparam int DEF_SYNC_STAGES = 2;

  localparam int PTR_W = 32;
  typedef logic [PTR_W-1:0] ptr_t;

  // Callers zero-extend narrower pointers; leading zeros keep the result exact.
  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_dc_prog_if.sv
// Producer/consumer bundle of the dual-clock FIFO.
interface fifo_dc_prog_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  overflow;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  underflow;

  modport master (
    output write, data_in, read,
    input  full, almost_full, wr_count, overflow,
    input  data_out, valid_out, empty, almost_empty,
    input  rd_count, underflow
  );

  modport slave (
    input  write, data_in, read,
    output full, almost_full, wr_count, overflow,
    output data_out, valid_out, empty, almost_empty,
    output rd_count, underflow
  );

endinterface

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus.
module cdc_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/fifo_dc_prog.sv
// Dual-clock FIFO with programmable thresholds and optional FWFT output.
module fifo_dc_prog
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int AF_LEVEL    = DEF_AF_LEVEL,
  parameter int AE_LEVEL    = DEF_AE_LEVEL,
  parameter int FWFT        = 0,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic           clk_w,
  input logic           rst_w,
  input logic           clk_r,
  input logic           rst_r,
  fifo_dc_prog_if.slave bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [PW-1:0] p_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  p_t   wr_bin, wr_gray, wr_bin_nxt, wr_gray_nxt;
  p_t   rq_gray, rq_bin, wr_cnt_nxt, full_gray;
  logic wr_en;

  p_t   rd_bin, rd_gray, rd_bin_nxt, rd_gray_nxt;
  p_t   wq_gray, wq_bin, rd_cnt_nxt;
  logic pop;

  always_comb begin
    wr_en       = bus.write && !bus.full;
    wr_bin_nxt  = wr_bin + p_t'(wr_en);
    wr_gray_nxt = p_t'(bin2gray(ptr_t'(wr_bin_nxt)));
    rq_bin      = p_t'(gray2bin(ptr_t'(rq_gray)));
    wr_cnt_nxt  = wr_bin_nxt - rq_bin;
    // Gray full pattern: read pointer one lap behind
    full_gray   = {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]};
  end

  always_ff @(posedge clk_w or posedge rst_w) begin
    if (rst_w) begin
      wr_bin          <= '0;
      wr_gray         <= '0;
      bus.wr_count    <= '0;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      wr_bin          <= wr_bin_nxt;
      wr_gray         <= wr_gray_nxt;
      bus.wr_count    <= wr_cnt_nxt;
      bus.full        <= (wr_gray_nxt == full_gray);
      bus.almost_full <= (32'(wr_cnt_nxt) >= AF_LEVEL);
      bus.overflow    <= bus.write && bus.full;
    end
  end

  always_ff @(posedge clk_w) begin
    if (wr_en)
      mem[wr_bin[ADDR_WIDTH-1:0]] <= bus.data_in;
  end

  cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk (clk_w),
    .rst (rst_w),
    .d   (rd_gray),
    .q   (rq_gray)
  );

  cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk (clk_r),
    .rst (rst_r),
    .d   (wr_gray),
    .q   (wq_gray)
  );

  always_comb begin
    rd_bin_nxt  = rd_bin + p_t'(pop);
    rd_gray_nxt = p_t'(bin2gray(ptr_t'(rd_bin_nxt)));
    wq_bin      = p_t'(gray2bin(ptr_t'(wq_gray)));
    rd_cnt_nxt  = wq_bin - rd_bin_nxt;
  end

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      rd_bin           <= '0;
      rd_gray          <= '0;
      bus.rd_count     <= '0;
      bus.empty        <= 1'b1;
      bus.almost_empty <= 1'b1;
    end else begin
      rd_bin           <= rd_bin_nxt;
      rd_gray          <= rd_gray_nxt;
      bus.rd_count     <= rd_cnt_nxt;
      bus.empty        <= (rd_gray_nxt == wq_gray);
      bus.almost_empty <= (32'(rd_cnt_nxt) <= AE_LEVEL);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Prefetch whenever the output register is free or being consumed
      assign pop = !bus.empty && (!bus.valid_out || bus.read);

      always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
          bus.data_out  <= '0;
          bus.valid_out <= 1'b0;
          bus.underflow <= 1'b0;
        end else begin
          bus.underflow <= bus.read && !bus.valid_out;
          if (pop) begin
            bus.data_out  <= mem[rd_bin[ADDR_WIDTH-1:0]];
            bus.valid_out <= 1'b1;
          end else if (bus.read) begin
            bus.valid_out <= 1'b0;
          end
        end
      end
    end else begin : g_std
      assign pop = bus.read && !bus.empty;

      always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
          bus.data_out  <= '0;
          bus.valid_out <= 1'b0;
          bus.underflow <= 1'b0;
        end else begin
          bus.underflow <= bus.read && bus.empty;
          bus.valid_out <= pop;
          if (pop)
            bus.data_out <= mem[rd_bin[ADDR_WIDTH-1:0]];
        end
      end
    end
  endgenerate

endmodule

// File: doc/fifo_dc_prog.md
FIFO_DC_PROG -- requirements
Module: fifo_dc_prog

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, log2 of depth; depth = 2**ADDR_WIDTH, all entries usable.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter AF_LEVEL, default 12, almost_full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-005 SHALL have parameter FWFT, default 0; 1 selects first-word-fall-through read mode.
REQ-006 SHALL have parameter SYNC_STAGES, default 2, min 2, synchronizer depth per crossing.
REQ-007 Reset rst_w SHALL be asynchronous, active-high; clock clk_w.
REQ-008 clk_w  in  1  write clock.
REQ-009 rst_w  in  1  write-domain reset.
REQ-010 clk_r  in  1  read clock.
REQ-011 rst_r  in  1  read-domain reset, asynchronous, active-high.
REQ-012 write  in  1  write request.
REQ-013 data_in  in  DATA_WIDTH  write data.
REQ-014 full / almost_full  out  1 each  write-side status.
REQ-015 wr_count  out  ADDR_WIDTH+1  fill level seen from write domain.
REQ-016 overflow  out  1  one-cycle pulse, write while full.
REQ-017 read  in  1  read request (FWFT: acknowledge of current head).
REQ-018 data_out  out  DATA_WIDTH  read data.
REQ-019 valid_out  out  1  data_out valid.
REQ-020 empty / almost_empty  out  1 each  read-side status.
REQ-021 rd_count  out  ADDR_WIDTH+1  fill level seen from read domain.
REQ-022 underflow  out  1  one-cycle pulse, read with no data.

Function
REQ-023 Pointers SHALL be ADDR_WIDTH+1 bits, binary and Gray copies, registered; only Gray copies cross domains through SYNC_STAGES flops.
REQ-024 Write accepted iff write && !full; memory written at wr_ptr[ADDR_WIDTH-1:0], pointer +1 modulo 2**(ADDR_WIDTH+1).
REQ-025 full SHALL be registered: next Gray wr_ptr equals synced Gray rd_ptr with top two bits inverted.
REQ-026 wr_count = wr_ptr - gray2bin(synced rd_ptr), registered; almost_full = (next wr_count >= AF_LEVEL).
REQ-027 empty SHALL be registered: next Gray rd_ptr equals synced Gray wr_ptr; rd_count and almost_empty (<= AE_LEVEL) computed symmetrically.
REQ-028 FWFT=0: read && !empty pops; data_out registered, valid_out high exactly 1 clk_r later for one cycle; data_out holds otherwise.
REQ-029 FWFT=1: head word prefetched into output register; valid_out high while word present; read && valid_out consumes, next word presented next cycle if available; read with valid_out low is underflow.
REQ-030 FWFT=1: empty reflects memory only; valid_out is the consumer-facing status.
REQ-031 Write-to-empty deassert latency SHALL be SYNC_STAGES+1 clk_r cycles (FWFT valid_out: +1 more); read-to-full deassert SHALL be SYNC_STAGES+1 clk_w cycles.
REQ-032 Simultaneous write at full with read in other domain: write rejected (full is pessimistic), overflow pulses, no data corrupted.
REQ-033 Counts SHALL never exceed 2**ADDR_WIDTH; status flags SHALL be conservative (never report space/data not present).

Reset
REQ-034 rst_w SHALL clear wr_ptr, write-side synchronizer, wr_count=0, full=0, almost_full=0, overflow=0.
REQ-035 rst_r SHALL clear rd_ptr, read-side synchronizer, rd_count=0, empty=1, almost_empty=1, valid_out=0, underflow=0, data_out=0.
REQ-036 Both resets SHALL be asserted together for >= SYNC_STAGES+1 cycles of slower clock; single-domain reset mid-operation leaves contents undefined, flags still at reset values.
REQ-037 Memory array SHALL not be reset.

Structure
REQ-038 Package fifo_pkg SHALL hold bin2gray/gray2bin functions and default constants.
REQ-039 Synchronizer SHALL be sub-module cdc_sync_bus (width, SYNC_STAGES, async reset), instantiated twice.

Verification
REQ-040 ADDR_WIDTH=3, clk_w 100 MHz, clk_r 37 MHz: write 0x01..0x08 -> full=1, wr_count=8; 9th write -> overflow pulse, data dropped; reads return 0x01..0x08 in order, then empty=1.
REQ-041 Empty FIFO, FWFT=0: single write 0xA5 -> empty falls 3 clk_r later; read -> valid_out 1 cycle later, data_out=0xA5; extra read -> underflow pulse.
REQ-042 FWFT=1: write 0x11,0x22 -> valid_out high with data_out=0x11 without read; read -> 0x22 next cycle; read -> valid_out=0.
REQ-043 AF_LEVEL=6, AE_LEVEL=2, depth 8: almost_full rises on 6th write; almost_empty falls once rd_count=3.
REQ-044 Continuous random-rate traffic, 10000 words, pointers wrap >100 times: scoreboard zero mismatches, no overflow/underflow when flags honoured.
REQ-045 Both resets asserted mid-stream with 5 words stored -> all outputs at REQ-034/035 values; subsequent write/read of 0x3C returns 0x3C.
